// File: rtl/cache_memory_assoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared FSM state encoding and address-field width helpers
//                for the 2-way set-associative cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    // Width of the word-offset field
    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Width of the set-index field
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Width of the tag field (byte-offset bits [1:0] are dropped)
    function automatic int tag_w(input int addr_w, input int sets, input int words_per_line);
        return addr_w - 2 - off_w(words_per_line) - idx_w(sets);
    endfunction

    // Field widths for the default geometry
    localparam int OFF_W = off_w(4);
    localparam int IDX_W = idx_w(16);
    localparam int TAG_W = tag_w(32, 16, 4);

endpackage
`default_nettype wire

// File: rtl/cache_way_store.sv
`default_nettype none
// ============================================================================
//  Module      : cache_way_store
//  Description : One way of the cache: tag, valid, dirty and data arrays.
//                Asynchronous read at (idx, rd_off); synchronous metadata and
//                data writes. Only valid/dirty bits are reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_way_store
    import cache_pkg::*;
#(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int DATA_W         = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [idx_w(SETS)-1:0]            idx,
    input  logic [off_w(WORDS_PER_LINE)-1:0]  rd_off,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [DATA_W-1:0]                 rd_data,
    input  logic                              meta_we,
    input  logic [TAG_W-1:0]                  meta_tag,
    input  logic                              meta_dirty,
    input  logic                              data_we,
    input  logic [off_w(WORDS_PER_LINE)-1:0]  wr_off,
    input  logic [DATA_W-1:0]                 wr_data
);

    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [DATA_W-1:0] r_data [SETS*WORDS_PER_LINE];

    // Line state bits: cleared by reset, a metadata write marks the line valid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (meta_we) begin
            r_valid[idx] <= 1'b1;
            r_dirty[idx] <= meta_dirty;
        end
    end

    // Tag and data storage, never reset
    always_ff @(posedge clk) begin
        if (meta_we) begin
            r_tag[idx] <= meta_tag;
        end
        if (data_we) begin
            r_data[{idx, wr_off}] <= wr_data;
        end
    end

    assign rd_tag   = r_tag[idx];
    assign rd_valid = r_valid[idx];
    assign rd_dirty = r_dirty[idx];
    assign rd_data  = r_data[{idx, rd_off}];

endmodule
`default_nettype wire

// File: rtl/cache_memory_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : cache_memory_assoc
//  Description : 2-way set-associative write-back / write-allocate data cache
//                with per-set LRU. Misses perform a dirty write-back then a
//                word-serial refill over a handshaked memory port.
//                Optional macro CACHE_STATS_EN adds saturating hit_count and
//                miss_count outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_memory_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int c_off_w = off_w(WORDS_PER_LINE);
    localparam int c_idx_w = idx_w(SETS);
    localparam int c_tag_w = tag_w(ADDR_W, SETS, WORDS_PER_LINE);
    localparam logic [c_off_w-1:0] c_last_word = c_off_w'(WORDS_PER_LINE - 1);

    state_t               r_state;
    logic                 r_write;
    logic [c_tag_w-1:0]   r_tag;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_off_w-1:0]   r_off;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_victim;
    logic [c_tag_w-1:0]   r_vtag;
    logic [c_off_w-1:0]   r_k;
    logic                 r_waiting;
    logic [SETS-1:0]      r_lru;     // 1: way1 is least recently used

    logic [c_tag_w-1:0]   w_way_tag   [2];
    logic [DATA_W-1:0]    w_way_rdata [2];
    logic [1:0]           w_way_valid;
    logic [1:0]           w_way_dirty;
    logic [1:0]           w_hit_vec;
    logic                 w_hit;
    logic                 w_hit_way;
    logic                 w_victim;
    logic [1:0]           w_meta_we;
    logic [1:0]           w_data_we;
    logic                 w_meta_dirty;
    logic [c_off_w-1:0]   w_rd_off;
    logic [c_off_w-1:0]   w_wr_off;
    logic [DATA_W-1:0]    w_wr_data;
    logic                 w_unused_lsbs;

    // Byte-within-word bits carry no information for a word cache
    assign w_unused_lsbs = ^req_addr[1:0];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_way
            cache_way_store #(
                .SETS           (SETS),
                .WORDS_PER_LINE (WORDS_PER_LINE),
                .TAG_W          (c_tag_w),
                .DATA_W         (DATA_W)
            ) u_store (
                .clk        (clk),
                .reset_n    (reset_n),
                .idx        (r_idx),
                .rd_off     (w_rd_off),
                .rd_tag     (w_way_tag[g]),
                .rd_valid   (w_way_valid[g]),
                .rd_dirty   (w_way_dirty[g]),
                .rd_data    (w_way_rdata[g]),
                .meta_we    (w_meta_we[g]),
                .meta_tag   (r_tag),
                .meta_dirty (w_meta_dirty),
                .data_we    (w_data_we[g]),
                .wr_off     (w_wr_off),
                .wr_data    (w_wr_data)
            );
            assign w_hit_vec[g] = w_way_valid[g] && (w_way_tag[g] == r_tag);
        end
    endgenerate

    assign w_hit     = |w_hit_vec;
    assign w_hit_way = ~w_hit_vec[0];
    assign w_victim  = !w_way_valid[0] ? 1'b0 :
                       !w_way_valid[1] ? 1'b1 : r_lru[r_idx];
    assign w_rd_off  = (r_state == WRITEBACK) ? r_k : r_off;

    // Array write strobes: hit-write, refill beat, and final line install
    always_comb begin
        w_meta_we    = 2'b00;
        w_data_we    = 2'b00;
        w_meta_dirty = 1'b0;
        w_wr_off     = r_off;
        w_wr_data    = r_wdata;
        case (r_state)
            LOOKUP: begin
                if (w_hit && r_write) begin
                    w_meta_we[w_hit_way] = 1'b1;
                    w_data_we[w_hit_way] = 1'b1;
                    w_meta_dirty         = 1'b1;
                end
            end
            REFILL: begin
                if (r_waiting && mem_rvalid) begin
                    w_data_we[r_victim] = 1'b1;
                    w_wr_off            = r_k;
                    w_wr_data           = mem_rdata;
                end
            end
            RESPOND: begin
                w_meta_we[r_victim] = 1'b1;
                w_meta_dirty        = r_write;
                w_data_we[r_victim] = r_write;
            end
            default: ;
        endcase
    end

    // Request/miss controller with registered CPU and memory outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_lru         <= '0;
            r_k           <= '0;
            r_waiting     <= 1'b0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_wdata     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        r_write   <= req_write;
                        r_wdata   <= req_wdata;
                        r_off     <= req_addr[2 +: c_off_w];
                        r_idx     <= req_addr[2 + c_off_w +: c_idx_w];
                        r_tag     <= req_addr[ADDR_W-1 -: c_tag_w];
                        req_ready <= 1'b0;
                        r_state   <= LOOKUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        resp_valid   <= 1'b1;
                        resp_hit     <= 1'b1;
                        resp_rdata   <= r_write ? '0 : w_way_rdata[w_hit_way];
                        r_lru[r_idx] <= ~w_hit_way;
                        r_state      <= IDLE;
                    end else begin
                        r_victim <= w_victim;
                        r_vtag   <= w_way_tag[w_victim];
                        r_k      <= '0;
                        r_state  <= (w_way_valid[w_victim] && w_way_dirty[w_victim])
                                    ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (!mem_req_valid) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= {r_vtag, r_idx, r_k, 2'b00};
                        mem_wdata     <= w_way_rdata[r_victim];
                    end else if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_write <= 1'b0;
                        if (r_k == c_last_word) begin
                            r_k     <= '0;
                            r_state <= REFILL;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                REFILL: begin
                    if (!mem_req_valid && !r_waiting) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= {r_tag, r_idx, r_k, 2'b00};
                    end else if (mem_req_valid && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_waiting     <= 1'b1;
                    end else if (r_waiting && mem_rvalid) begin
                        r_waiting <= 1'b0;
                        if (r_k == c_last_word) begin
                            r_k     <= '0;
                            r_state <= RESPOND;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    resp_valid   <= 1'b1;
                    resp_hit     <= 1'b0;
                    resp_rdata   <= r_write ? '0 : w_way_rdata[r_victim];
                    r_lru[r_idx] <= ~r_victim;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating lookup outcome counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_memory_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_memory_assoc
//  Description : Self-checking bench for cache_memory_assoc: directed
//                scenarios then randomized traffic against a behavioural
//                cache/memory model; a concurrent memory responder.
//                Optional macro CACHE_STATS_EN checks the statistics ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_memory_assoc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_memory_assoc dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_rdata    (resp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory seen by the DUT, and the model's own memory image
    logic [31:0] mem_img [bit [31:0]];
    logic [31:0] ref_img [bit [31:0]];

    function automatic logic [31:0] dflt(input bit [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: random ready, one read answered 0..2 cycles later
    // ------------------------------------------------------------------
    logic [63:0] wr_log [$];
    logic [31:0] rd_log [$];
    logic [31:0] rd_q   [$];
    int          rd_delay  = 0;
    int          hold_cnt  = 0;
    int          rv_count  = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_write;

    initial begin
        logic        rdy;
        logic [31:0] a;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!reset_n) begin
                rd_q.delete();
                prev_stall    = 1'b0;
                mem_req_ready = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("mem_hold_valid", mem_req_valid, 1);
                    check("mem_hold_addr", mem_req_addr, prev_addr);
                    check("mem_hold_write", mem_req_write, prev_write);
                    if (prev_write) check("mem_hold_wdata", mem_wdata, prev_wdata);
                end
                if (rd_q.size() > 0) begin
                    if (rd_delay == 0) begin
                        a          = rd_q.pop_front();
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_img.exists(a) ? mem_img[a] : dflt(a);
                        rv_count++;
                    end else begin
                        rd_delay--;
                    end
                end
                rdy = ($urandom_range(0, 3) != 0);
                if (hold_cnt > 0 && mem_req_valid && !mem_req_write) begin
                    rdy = 1'b0;
                    hold_cnt--;
                    check("hold_req_ready", req_ready, 0);
                end
                mem_req_ready = rdy;
                if (mem_req_valid && rdy) begin
                    if (mem_req_write) begin
                        mem_img[mem_req_addr] = mem_wdata;
                        wr_log.push_back({mem_req_addr, mem_wdata});
                    end else begin
                        rd_log.push_back(mem_req_addr);
                        rd_q.push_back(mem_req_addr);
                        rd_delay = $urandom_range(0, 2);
                    end
                end
                prev_stall = mem_req_valid && !rdy;
                prev_addr  = mem_req_addr;
                prev_write = mem_req_write;
                prev_wdata = mem_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: lines per (set, way) with last-use timestamps
    // ------------------------------------------------------------------
    bit          mv   [16][2];
    bit          md   [16][2];
    logic [31:0] mt   [16][2];
    logic [31:0] mdat [16][2][4];
    int          lu   [16][2];
    int          tick = 0;
    int          exp_hits = 0, exp_misses = 0;
    logic [63:0] exp_wr [$];
    logic [31:0] exp_rd [$];
    logic        last_hit;
    logic [31:0] last_rdata;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                output bit ehit, output logic [31:0] erd);
        int          idx, off, way;
        logic [31:0] tg, a, base;
        idx = int'((addr >> 4) & 32'hF);
        off = int'((addr >> 2) & 32'h3);
        tg  = addr >> 8;
        way = -1;
        exp_wr.delete();
        exp_rd.delete();
        tick++;
        for (int w = 0; w < 2; w++) if (mv[idx][w] && mt[idx][w] == tg) way = w;
        if (way >= 0) begin
            ehit = 1'b1;
            exp_hits++;
        end else begin
            ehit = 1'b0;
            exp_misses++;
            if (!mv[idx][0])      way = 0;
            else if (!mv[idx][1]) way = 1;
            else                  way = (lu[idx][0] < lu[idx][1]) ? 0 : 1;
            if (mv[idx][way] && md[idx][way]) begin
                for (int k = 0; k < 4; k++) begin
                    a = (mt[idx][way] << 8) | 32'(idx * 16 + k * 4);
                    exp_wr.push_back({a, mdat[idx][way][k]});
                    ref_img[a] = mdat[idx][way][k];
                end
            end
            base = (tg << 8) | 32'(idx * 16);
            for (int k = 0; k < 4; k++) begin
                a = base + 32'(k * 4);
                exp_rd.push_back(a);
                mdat[idx][way][k] = ref_img.exists(a) ? ref_img[a] : dflt(a);
            end
            mv[idx][way] = 1'b1;
            md[idx][way] = 1'b0;
            mt[idx][way] = tg;
        end
        if (wr) begin
            mdat[idx][way][off] = wd;
            md[idx][way]        = 1'b1;
            erd                 = '0;
        end else begin
            erd = mdat[idx][way][off];
        end
        lu[idx][way] = tick;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_img[a] = d;
        ref_img[a] = d;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_hit"}, resp_hit, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_req_write"}, mem_req_write, 0);
        check({tag, "_mem_req_addr"}, mem_req_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
`ifdef CACHE_STATS_EN
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_miss_count"}, miss_count, 0);
`endif
    endtask

    // Issue one request and wait for the response; blocking with time bounds
    task automatic send_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        bit          eh;
        logic [31:0] er;
        int          lat;
        model_access(wr, addr, wd, eh, er);
        wr_log.delete();
        rd_log.delete();
        send_req(wr, addr, wd);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        check("resp_seen", resp_valid, 1);
        check("resp_hit", resp_hit, eh);
        check("resp_rdata", resp_rdata, er);
        check("ready_low_in_resp", req_ready, 0);
        if (eh) check("hit_latency", lat, 2);
        last_hit   = resp_hit;
        last_rdata = resp_rdata;
        @(negedge clk);
        check("resp_pulse", resp_valid, 0);
        check("ready_after_resp", req_ready, 1);
        check("wb_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check("wb_word", wr_log[i], exp_wr[i]);
        check("refill_count", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check("refill_addr", rd_log[i], exp_rd[i]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rv, n;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Scenario 1: cold read miss then hit on the same line
        for (int k = 0; k < 4; k++) preload(32'h100 + 32'(k * 4), 32'hA0 + 32'(k));
        do_req(1'b0, 32'h100, '0);
        check("t1_miss_hit", last_hit, 0);
        check("t1_miss_data", last_rdata, 32'hA0);
        do_req(1'b0, 32'h104, '0);
        check("t1_hit_data", last_rdata, 32'hA1);
`ifdef CACHE_STATS_EN
        check("t6_hits", hit_count, 1);
        check("t6_misses", miss_count, 1);
`endif

        // Scenario 2: write-allocate into way1 of set 0
        do_req(1'b1, 32'h204, 32'hDEAD_BEEF);
        check("t2_no_wb", wr_log.size(), 0);
        do_req(1'b0, 32'h204, '0);
        check("t2_hit_data", last_rdata, 32'hDEAD_BEEF);

        // Scenario 3: clean victim, then dirty victim write-back
        do_req(1'b0, 32'h300, '0);
        check("t3_clean_no_wb", wr_log.size(), 0);
        do_req(1'b0, 32'h400, '0);
        check("t3_wb_count", wr_log.size(), 4);
        if (wr_log.size() > 1) check("t3_wb_word1", wr_log[1], {32'h204, 32'hDEAD_BEEF});

        // Scenario 4: memory stalls five cycles during refill
        hold_cnt = 5;
        do_req(1'b0, 32'h500, '0);
        check("t4_hold_used", hold_cnt, 0);

        // Scenario 5: reset in the middle of a refill
        base_rv = rv_count;
        send_req(1'b0, 32'h600, '0);
        n = 0;
        while (rv_count < base_rv + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_two_beats", rv_count >= base_rv + 2, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("t5_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_req(1'b0, 32'h600, '0);
        check("t5_miss_after_reset", last_hit, 0);

        // Randomized traffic over a few sets and conflicting tags
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
`ifdef CACHE_STATS_EN
        check("stats_hits", hit_count, exp_hits);
        check("stats_misses", miss_count, exp_misses);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_memory_assoc.md
Name: cache_memory_assoc

Overview:
Parametrised successor of the team's direct-mapped cache: 2-way set-associative, write-back/write-allocate data cache with per-set LRU replacement. Sits between a CPU-side request/response port and a word-serial memory port. Misses run a dirty write-back and a line refill through a handshaked FSM. All state is owned here; the memory model or controller sits behind the mem_* port.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width; addresses are word-aligned, addr[1:0] ignored
SETS, 16, number of sets; power of two, >=2
WORDS_PER_LINE, 4, words per line; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_hit  out  1  1 if request hit on lookup
resp_rdata  out  DATA_W  read data; 0 for writes
mem_req_valid  out  1  memory word request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=write-back word, 0=refill read
mem_req_addr  out  ADDR_W  word-aligned byte address
mem_wdata  out  DATA_W  write-back data
mem_rvalid  in  1  refill data valid, in request order
mem_rdata  in  DATA_W  refill data

Behaviour:
- Address split: offset=addr[OFF+1:2], OFF=log2(WORDS_PER_LINE); index=next log2(SETS) bits; tag=remaining upper bits.
- Reset (reset_n low at clk edge): all valid, dirty and LRU bits cleared; FSM to IDLE; all outputs 0 except req_ready=1 after reset release. Data/tag arrays are not reset. Reset mid-operation abandons the transaction with no response.
- FSM: IDLE -> LOOKUP -> {IDLE on hit | WRITEBACK | REFILL} ; WRITEBACK -> REFILL -> RESPOND -> IDLE.
- IDLE: request accepted on req_valid&&req_ready; request is registered.
- LOOKUP (1 cycle): compare both ways. Hit: read returns word, write updates word and sets dirty; resp_valid=1, resp_hit=1 in the next cycle (hit latency 2 cycles from acceptance); LRU[set] points to the other way.
- Victim on miss: first invalid way (way0 preferred), else the LRU way.
- WRITEBACK (victim valid and dirty): WORDS_PER_LINE write requests, addresses {victim_tag,index,k,2'b00}, k=0..N-1 ascending.
- REFILL: WORDS_PER_LINE read requests, k ascending; one request outstanding at a time, next issued after mem_rvalid. Words stored into victim way.
- mem_req_valid, addr, write and wdata stay stable until mem_req_ready; mem_rvalid outside REFILL is ignored.
- RESPOND: write miss merges req_wdata after refill, dirty=1; read miss dirty=0; valid=1, tag updated; LRU points to the other way; resp_valid=1, resp_hit=0, resp_rdata=requested word for reads.
- resp_valid and resp_hit are deasserted in every cycle other than the response cycle. req_ready is low from acceptance until the cycle after resp_valid.

Optional Feature:
CACHE_STATS_EN: adds outputs hit_count and miss_count, 32 bits each, saturating at 0xFFFF_FFFF, incremented in the LOOKUP cycle and cleared by reset. Without the macro, these ports and counters do not exist.

Decomposition:
- Package cache_pkg holds: FSM state enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND) and width functions/localparams (OFF_W, IDX_W, TAG_W).
- Sub-module cache_way_store holds one way's tag/valid/dirty/data array with read and write ports; it is instantiated twice.

Test Plan (SETS=16, WORDS_PER_LINE=4):
1. Reset, read 0x100 -> miss; reads issued to 0x100, 0x104, 0x108, 0x10C. Memory returns 0xA0..0xA3; resp_rdata=0xA0, resp_hit=0. Then read 0x104 -> resp_hit=1, resp_rdata=0xA1, 2 cycles after acceptance.
2. Write 0x204 with 0xDEADBEEF -> miss into way1 of set 0, refill, no memory writes. Then read 0x204 -> hit, 0xDEADBEEF.
3. Read 0x300 -> LRU way0 (clean) is victim; no write-back, refill only. Then read 0x400 -> victim is dirty way1; writes to 0x200..0x20C with word1=0xDEADBEEF, then refill.
4. Hold mem_req_ready low 5 cycles during refill -> mem_req_valid, addr and write stay stable; req_ready=0 throughout.
5. Assert reset_n=0 after 2 refill beats -> next cycle all outputs 0, no resp_valid. Repeating the read then misses.
6. With CACHE_STATS_EN, run scenario 1 -> hit_count=1, miss_count=1. Reset -> both 0.
